// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core pipeline registers.
package cpu_pkg;

   localparam int unsigned EXC_NONE     = 0;
   localparam logic [31:0] NOP_IR_DEF   = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam int unsigned PC_STEP8     = 8;

   // What a stage register does on the coming edge
   typedef enum logic [1:0] {
      ActLoad,
      ActStall,
      ActFlush
   } stage_act_e;

   // Flush beats stall, stall beats load
   function automatic stage_act_e stage_act(input logic flush, input logic stall);
      if (flush) begin
         return ActFlush;
      end
      if (stall) begin
         return ActStall;
      end
      return ActLoad;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // Next count: clear, else increment until all-ones
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register, asynchronous reset to zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: instruction, PC, PC+8, exception code and
// delay-slot flag, with stall/flush control and stall/bubble counters.
module pipe_stage_reg
   import cpu_pkg::*;
#(
   parameter int unsigned     IR_W             = 32,
   parameter int unsigned     PC_W             = 32,
   parameter int unsigned     EXC_W            = 5,
   parameter logic [PC_W-1:0] RESET_PC         = PC_W'(RESET_PC_DEF),
   parameter logic [IR_W-1:0] NOP_IR           = IR_W'(NOP_IR_DEF),
   parameter bit              KEEP_PC_ON_FLUSH = 1'b1,
   parameter int unsigned     CNT_W            = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [IR_W-1:0]  in_ir,
   input  logic [PC_W-1:0]  in_pc,
   input  logic [EXC_W-1:0] in_exc,
   input  logic             in_bd,
   output logic             out_valid,
   output logic [IR_W-1:0]  out_ir,
   output logic [PC_W-1:0]  out_pc,
   output logic [PC_W-1:0]  out_pc8,
   output logic [EXC_W-1:0] out_exc,
   output logic             out_bd,
   output logic [CNT_W-1:0] stall_run,
   output logic [CNT_W-1:0] bubble_cnt
);

   stage_act_e act;

   logic             valid_q, valid_d;
   logic [IR_W-1:0]  ir_q, ir_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  pc8_q, pc8_d;
   logic [EXC_W-1:0] exc_q, exc_d;
   logic             bd_q, bd_d;

   assign act = stage_act(flush, stall);

   // Payload next state; PC+8 always tracks the PC being registered
   always_comb begin
      valid_d = valid_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      exc_d   = exc_q;
      bd_d    = bd_q;
      unique case (act)
         ActFlush: begin
            valid_d = 1'b0;
            ir_d    = NOP_IR;
            exc_d   = EXC_W'(EXC_NONE);
            if (KEEP_PC_ON_FLUSH) begin
               // Bubble keeps the PC/BD of the squashed slot as an EPC source
               pc_d = in_pc;
               bd_d = in_bd;
            end else begin
               pc_d = RESET_PC;
               bd_d = 1'b0;
            end
         end
         ActStall: begin
         end
         ActLoad: begin
            valid_d = in_valid;
            ir_d    = in_valid ? in_ir : NOP_IR;
            exc_d   = in_valid ? in_exc : EXC_W'(EXC_NONE);
            pc_d    = in_pc;
            bd_d    = in_bd;
         end
         default: begin
         end
      endcase
      pc8_d = pc_d + PC_W'(PC_STEP8);
   end

   // Payload registers, asynchronous reset to an invalid NOP at RESET_PC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         ir_q    <= NOP_IR;
         pc_q    <= RESET_PC;
         pc8_q   <= RESET_PC + PC_W'(PC_STEP8);
         exc_q   <= EXC_W'(EXC_NONE);
         bd_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         pc8_q   <= pc8_d;
         exc_q   <= exc_d;
         bd_q    <= bd_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_run (
      .clk   (clk),
      .reset (reset),
      .inc   (act == ActStall),
      .clr   (act != ActStall),
      .count (stall_run)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (act == ActFlush),
      .clr   (1'b0),
      .count (bubble_cnt)
   );

   assign out_valid = valid_q;
   assign out_ir    = ir_q;
   assign out_pc    = pc_q;
   assign out_pc8   = pc8_q;
   assign out_exc   = exc_q;
   assign out_bd    = bd_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (PC kept on flush with 16-bit
// counters, PC reset on flush with 3-bit counters) driven by the same inputs.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_ir = '0;
   logic [31:0] in_pc = '0;
   logic [4:0]  in_exc = '0;
   logic        in_bd = 1'b0;

   logic        a_valid, b_valid, a_bd, b_bd;
   logic [31:0] a_ir, b_ir, a_pc, b_pc, a_pc8, b_pc8;
   logic [4:0]  a_exc, b_exc;
   logic [15:0] a_srun, a_bub;
   logic [2:0]  b_srun, b_bub;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .KEEP_PC_ON_FLUSH (1'b1),
      .CNT_W            (16)
   ) dut_a (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ir      (in_ir),
      .in_pc      (in_pc),
      .in_exc     (in_exc),
      .in_bd      (in_bd),
      .out_valid  (a_valid),
      .out_ir     (a_ir),
      .out_pc     (a_pc),
      .out_pc8    (a_pc8),
      .out_exc    (a_exc),
      .out_bd     (a_bd),
      .stall_run  (a_srun),
      .bubble_cnt (a_bub)
   );

   pipe_stage_reg #(
      .KEEP_PC_ON_FLUSH (1'b0),
      .CNT_W            (3)
   ) dut_b (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ir      (in_ir),
      .in_pc      (in_pc),
      .in_exc     (in_exc),
      .in_bd      (in_bd),
      .out_valid  (b_valid),
      .out_ir     (b_ir),
      .out_pc     (b_pc),
      .out_pc8    (b_pc8),
      .out_exc    (b_exc),
      .out_bd     (b_bd),
      .stall_run  (b_srun),
      .bubble_cnt (b_bub)
   );

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          valid;
      logic [31:0] ir;
      logic [31:0] pc;
      logic [4:0]  exc;
      bit          bd;
      int          srun;
      int          bub;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t m_reset();
      mstate_t s;
      s.valid = 1'b0; s.ir = 32'h0; s.pc = 32'h3000; s.exc = 5'd0; s.bd = 1'b0;
      s.srun = 0; s.bub = 0;
      return s;
   endfunction

   function automatic int sat_inc(input int v, input int maxc);
      return (v + 1 > maxc) ? maxc : v + 1;
   endfunction

   function automatic mstate_t m_next(input mstate_t s, input bit keep, input int maxc);
      mstate_t n = s;
      if (flush) begin
         n.valid = 1'b0; n.ir = 32'h0; n.exc = 5'd0;
         n.pc = keep ? in_pc : 32'h3000;
         n.bd = keep ? in_bd : 1'b0;
         n.bub = sat_inc(s.bub, maxc);
         n.srun = 0;
      end else if (stall) begin
         n.srun = sat_inc(s.srun, maxc);
      end else begin
         n.valid = in_valid;
         n.ir = in_valid ? in_ir : 32'h0;
         n.exc = in_valid ? in_exc : 5'd0;
         n.pc = in_pc;
         n.bd = in_bd;
         n.srun = 0;
      end
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ma = m_reset();
         mb = m_reset();
      end else begin
         ma = m_next(ma, 1'b1, 65535);
         mb = m_next(mb, 1'b0, 7);
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model, on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("a_valid", 32'(a_valid), 32'(ma.valid));
         cmp("a_ir", a_ir, ma.ir);
         cmp("a_pc", a_pc, ma.pc);
         cmp("a_pc8", a_pc8, ma.pc + 32'd8);
         cmp("a_exc", 32'(a_exc), 32'(ma.exc));
         cmp("a_bd", 32'(a_bd), 32'(ma.bd));
         cmp("a_srun", 32'(a_srun), 32'(ma.srun));
         cmp("a_bub", 32'(a_bub), 32'(ma.bub));
         cmp("b_valid", 32'(b_valid), 32'(mb.valid));
         cmp("b_ir", b_ir, mb.ir);
         cmp("b_pc", b_pc, mb.pc);
         cmp("b_pc8", b_pc8, mb.pc + 32'd8);
         cmp("b_exc", 32'(b_exc), 32'(mb.exc));
         cmp("b_bd", 32'(b_bd), 32'(mb.bd));
         cmp("b_srun", 32'(b_srun), 32'(mb.srun));
         cmp("b_bub", 32'(b_bub), 32'(mb.bub));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] ir, input logic [31:0] pc,
                        input logic [4:0] exc, input bit bd);
      in_valid = v; in_ir = ir; in_pc = pc; in_exc = exc; in_bd = bd;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      // 1. reset and first load
      #1 reset = 1'b1;
      #1;
      cmp("rst_pc", a_pc, 32'h3000);
      cmp("rst_pc8", a_pc8, 32'h3008);
      cmp("rst_ir", a_ir, 32'h0);
      cmp("rst_valid", 32'(a_valid), 32'h0);
      cmp("rst_bub", 32'(b_bub), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      drive(1'b1, 32'h3C01_0001, 32'h3000, 5'd0, 1'b0);
      tick();
      cmp("ld_ir", a_ir, 32'h3C01_0001);
      cmp("ld_pc8", a_pc8, 32'h3008);
      cmp("ld_valid", 32'(a_valid), 32'h1);

      // 2. stall hold
      stall = 1'b1;
      drive(1'b1, 32'h1234_5678, 32'h3004, 5'd0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         cmp("stall_ir", a_ir, 32'h3C01_0001);
         cmp("stall_run", 32'(a_srun), 32'(i));
      end
      stall = 1'b0;
      tick();
      cmp("unstall_ir", a_ir, 32'h1234_5678);
      cmp("unstall_run", 32'(a_srun), 32'h0);

      // 3. flush over stall, both PC-retention modes
      stall = 1'b1;
      flush = 1'b1;
      drive(1'b1, 32'h0000_0020, 32'h3010, 5'd0, 1'b1);
      tick();
      cmp("fl_valid", 32'(a_valid), 32'h0);
      cmp("fl_ir", a_ir, 32'h0);
      cmp("fl_keep_pc", a_pc, 32'h3010);
      cmp("fl_keep_bd", 32'(a_bd), 32'h1);
      cmp("fl_bub", 32'(a_bub), 32'h1);
      cmp("fl_nokeep_pc", b_pc, 32'h3000);
      cmp("fl_nokeep_bd", 32'(b_bd), 32'h0);
      stall = 1'b0;
      flush = 1'b0;

      // 4. invalid input squashes payload; PC+8 wraps
      drive(1'b0, 32'hDEAD_BEEF, 32'h3014, 5'd4, 1'b0);
      tick();
      cmp("inv_ir", a_ir, 32'h0);
      cmp("inv_exc", 32'(a_exc), 32'h0);
      cmp("inv_bub", 32'(a_bub), 32'h1);
      drive(1'b1, 32'h0000_0001, 32'hFFFF_FFFC, 5'd0, 1'b0);
      tick();
      cmp("wrap_pc8", a_pc8, 32'h0000_0004);
      drive(1'b1, 32'h0000_000C, 32'h0000_0004, 5'd5, 1'b1);
      tick();
      cmp("exc_load", 32'(a_exc), 32'd5);

      // 5. counter saturation (3-bit counters on dut_b)
      stall = 1'b1;
      repeat (10) tick();
      cmp("sat_srun_b", 32'(b_srun), 32'd7);
      cmp("sat_srun_a", 32'(a_srun), 32'd10);
      stall = 1'b0;
      flush = 1'b1;
      repeat (9) tick();
      cmp("sat_bub_b", 32'(b_bub), 32'd7);
      cmp("sat_bub_a", 32'(a_bub), 32'd10);
      flush = 1'b0;

      // 6. asynchronous reset in the middle of a stall
      drive(1'b1, 32'h2108_0003, 32'h4000, 5'd0, 1'b0);
      tick();
      stall = 1'b1;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      cmp("arst_valid", 32'(a_valid), 32'h0);
      cmp("arst_pc", a_pc, 32'h3000);
      cmp("arst_pc8", a_pc8, 32'h3008);
      cmp("arst_ir", a_ir, 32'h0);
      cmp("arst_srun", 32'(a_srun), 32'h0);
      cmp("arst_bub", 32'(a_bub), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      stall = 1'b0;
      drive(1'b1, 32'h3C01_0001, 32'h3000, 5'd0, 1'b0);
      tick();
      cmp("post_ir", a_ir, 32'h3C01_0001);
      cmp("post_valid", 32'(a_valid), 32'h1);
      cmp("post_pc8", a_pc8, 32'h3008);
      repeat (2) tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the five-stage MIPS core; one instance per stage boundary (F/D, D/E, E/M, M/W).
- Carries instruction word, PC, exception code and delay-slot flag.
- Derives PC+8 internally.
- Supports stall (hold), flush (bubble insertion) with a configurable PC-retention mode, and per-stage stall/bubble performance counters.

Parameters:
IR_W, 32, instruction word width
PC_W, 32, PC width
EXC_W, 5, exception code width (0 = no exception)
RESET_PC, 32'h0000_3000, PC value loaded on reset
NOP_IR, 32'h0000_0000, instruction word inserted on reset/flush
KEEP_PC_ON_FLUSH, 1, 1: bubble keeps incoming PC and BD flag (EPC source); 0: bubble takes RESET_PC and BD=0
CNT_W, 16, performance counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold current contents
flush  input  1  replace contents with bubble on next edge
in_valid  input  1  upstream slot holds a real instruction
in_ir  input  IR_W  next instruction word
in_pc  input  PC_W  next PC
in_exc  input  EXC_W  next exception code
in_bd  input  1  next instruction is in a branch delay slot
out_valid  output  1  registered valid
out_ir  output  IR_W  registered instruction
out_pc  output  PC_W  registered PC
out_pc8  output  PC_W  registered PC+8
out_exc  output  EXC_W  registered exception code
out_bd  output  1  registered delay-slot flag
stall_run  output  CNT_W  consecutive cycles currently stalled
bubble_cnt  output  CNT_W  total bubbles inserted since reset

Behaviour:
Reset values (reset asserted, immediate, asynchronous):
- out_valid=0, out_ir=NOP_IR, out_pc=RESET_PC, out_pc8=RESET_PC+8, out_exc=0, out_bd=0, stall_run=0, bubble_cnt=0.
- Reset mid-stall or mid-flush discards everything; first edge after deassertion applies the normal rules.

Edge priority, highest first: flush > stall > load.
- flush=1 (regardless of stall):
  - out_valid=0, out_ir=NOP_IR, out_exc=0.
  - KEEP_PC_ON_FLUSH=1: out_pc=in_pc, out_pc8=in_pc+8, out_bd=in_bd.
  - KEEP_PC_ON_FLUSH=0: out_pc=RESET_PC, out_pc8=RESET_PC+8, out_bd=0.
  - bubble_cnt += 1, saturating at all-ones.
  - stall_run=0.
- stall=1, flush=0:
  - All payload outputs hold.
  - stall_run += 1, saturating at all-ones.
  - bubble_cnt holds.
- stall=0, flush=0 (load):
  - out_valid=in_valid, out_ir=in_ir, out_pc=in_pc, out_pc8=in_pc+8, out_exc=in_exc, out_bd=in_bd.
  - stall_run=0.
  - If in_valid=0, out_ir is forced to NOP_IR and out_exc to 0. Not counted as a bubble.

Arithmetic and timing:
- PC+8 is computed modulo 2^PC_W; 32'hFFFF_FFFC yields 32'h0000_0004.
- Latency is one cycle; all outputs are registered, with no combinational path from input to output.
- out_pc8 is always out_pc+8 for the same registered value.

Decomposition:
Shared package cpu_pkg:
- EXC_NONE=0
- NOP_IR default
- RESET_PC default
- localparam PC_STEP8=8

Sub-module sat_counter (parameter W; inputs clk, reset, inc, clr; output count): one instance for stall_run (clr on load/flush), one for bubble_cnt (clr tied 0).

Payload datapath stays inline in pipe_stage_reg.

Test Plan:
1. Reset and load: reset high → out_pc=0x3000, out_pc8=0x3008, out_ir=0, out_valid=0. Release, drive in_ir=0x3C010001, in_pc=0x3000, in_valid=1 → next edge out_ir=0x3C010001, out_pc8=0x3008, out_valid=1.
2. Stall hold: after load, stall=1 for 3 cycles while in_ir toggles to 0x12345678 → outputs unchanged, stall_run=1,2,3. stall=0 → loads 0x12345678, stall_run=0.
3. Flush over stall: stall=1 and flush=1 together, in_pc=0x3010, in_bd=1, KEEP_PC_ON_FLUSH=1 → out_valid=0, out_ir=0, out_pc=0x3010, out_bd=1, bubble_cnt=1. Repeat with KEEP_PC_ON_FLUSH=0 → out_pc=0x3000, out_bd=0.
4. Invalid input and PC wrap: in_valid=0, in_ir=0xDEADBEEF, in_exc=4 → out_ir=0, out_exc=0, bubble_cnt unchanged. in_pc=0xFFFFFFFC, valid load → out_pc8=0x00000004.
5. Counter saturation with CNT_W=3: stall held 10 cycles → stall_run stops at 7. 9 flushes → bubble_cnt stops at 7.
6. Asynchronous reset mid-stall: assert reset between edges during stall → outputs go to reset values immediately, before the next edge. Release → first load behaves as in scenario 1.
